// File: rtl/countdown_pkg.sv
// Shared constants, state encoding and digit-clamp helpers for the seconds countdown.
// Consumed by countdown_sec and its seg7_encode digit decoders.
package countdown_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_PAUSE = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b0000001;

    localparam logic [2:0] MAX_TENS  = 3'd5;
    localparam logic [3:0] MAX_UNITS = 4'd9;

    function automatic logic [2:0] clamp_tens(input logic [2:0] i_tens);
        return (i_tens > MAX_TENS) ? MAX_TENS : i_tens;
    endfunction

    function automatic logic [3:0] clamp_units(input logic [3:0] i_units);
        return (i_units > MAX_UNITS) ? MAX_UNITS : i_units;
    endfunction

endpackage

// File: rtl/countdown_sec_seg7.sv
// BCD digit to active-low {a,b,c,d,e,f,g} segment decoder with a blanking input.
// Purely combinational; codes above 9 render blank.
module seg7_encode
    import countdown_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            case (i_bcd)
                4'd0:    o_seg = SEG_ZERO;
                4'd1:    o_seg = 7'b1001111;
                4'd2:    o_seg = 7'b0010010;
                4'd3:    o_seg = 7'b0000110;
                4'd4:    o_seg = 7'b1001100;
                4'd5:    o_seg = 7'b0100100;
                4'd6:    o_seg = 7'b0100000;
                4'd7:    o_seg = 7'b0001111;
                4'd8:    o_seg = 7'b0000000;
                4'd9:    o_seg = 7'b0000100;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/countdown_sec.sv
// Two-digit 59..00 seconds countdown with prescaler, borrow pulse, done flag and 7-seg drive.
// Optional COUNTDOWN_BLINK_EN: digits blink "00"/blank at half-second phases while in DONE.
module countdown_sec
    import countdown_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       LOAD,
    input  logic [2:0] LOAD_TENS,
    input  logic [3:0] LOAD_UNITS,
    input  logic       START,
    input  logic       STOP,
    output logic       BUSY,
    output logic       DONE,
    output logic       BORROW,
    output logic [6:0] SEG_U,
    output logic [6:0] SEG_T
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    state_t        r_state;
    logic [2:0]    r_tens;
    logic [3:0]    r_units;
    logic [PW-1:0] r_presc;
    logic          r_borrow;

    state_t        w_state_nxt;
    logic [2:0]    w_tens_nxt;
    logic [3:0]    w_units_nxt;
    logic [PW-1:0] w_presc_nxt;
    logic          w_borrow_nxt;

    logic w_wrap;
    logic w_is_zero;
    logic w_last_sec;
    logic w_blank;

    assign w_wrap     = (r_presc == PRESC_LAST);
    assign w_is_zero  = (r_tens == 3'd0) && (r_units == 4'd0);
    assign w_last_sec = (r_tens == 3'd0) && (r_units == 4'd1);

    // Command priority LOAD > STOP > START; STOP only acts in RUN, so it cannot mask START elsewhere.
    always_comb begin
        w_state_nxt  = r_state;
        w_tens_nxt   = r_tens;
        w_units_nxt  = r_units;
        w_presc_nxt  = r_presc;
        w_borrow_nxt = 1'b0;
        if (LOAD) begin
            w_tens_nxt  = clamp_tens(LOAD_TENS);
            w_units_nxt = clamp_units(LOAD_UNITS);
            w_presc_nxt = '0;
            w_state_nxt = ST_IDLE;
        end else if (STOP && (r_state == ST_RUN)) begin
            w_state_nxt = ST_PAUSE;
        end else if (START && ((r_state == ST_IDLE) || (r_state == ST_PAUSE))) begin
            if (w_is_zero) begin
                w_state_nxt = ST_DONE;
                w_presc_nxt = '0;
            end else begin
                w_state_nxt = ST_RUN;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_wrap) begin
                        w_presc_nxt = '0;
                        if (r_units == 4'd0) begin
                            w_units_nxt  = MAX_UNITS;
                            w_tens_nxt   = r_tens - 3'd1;
                            w_borrow_nxt = 1'b1;
                        end else begin
                            w_units_nxt = r_units - 4'd1;
                            if (w_last_sec) begin
                                w_state_nxt = ST_DONE;
                            end
                        end
                    end else begin
                        w_presc_nxt = r_presc + PW'(1);
                    end
                end
                ST_DONE: begin
`ifdef COUNTDOWN_BLINK_EN
                    w_presc_nxt = w_wrap ? '0 : (r_presc + PW'(1));
`else
                    w_presc_nxt = '0;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= ST_IDLE;
            r_tens   <= 3'd0;
            r_units  <= 4'd0;
            r_presc  <= '0;
            r_borrow <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_tens   <= w_tens_nxt;
            r_units  <= w_units_nxt;
            r_presc  <= w_presc_nxt;
            r_borrow <= w_borrow_nxt;
        end
    end

`ifdef COUNTDOWN_BLINK_EN
    localparam logic [PW-1:0] PRESC_HALF = PW'(TICKS_PER_SEC / 2);
    assign w_blank = (r_state == ST_DONE) && (r_presc >= PRESC_HALF);
`else
    assign w_blank = 1'b0;
`endif

    assign BUSY   = (r_state == ST_RUN);
    assign DONE   = (r_state == ST_DONE);
    assign BORROW = r_borrow;

    seg7_encode u_seg_units (
        .i_bcd   (r_units),
        .i_blank (w_blank),
        .o_seg   (SEG_U)
    );

    seg7_encode u_seg_tens (
        .i_bcd   ({1'b0, r_tens}),
        .i_blank (w_blank),
        .o_seg   (SEG_T)
    );

endmodule
